// File: rtl/cross_bar_nxm.sv
`default_nettype none
// ============================================================================
// Module   : cross_bar_nxm
// Purpose  : Parametrised NUM_M-master x NUM_S-slave request/acknowledge
//            crossbar. Each slave port owns an IDLE/GRANT/RESP state machine
//            and a round-robin arbiter, so different slaves serve different
//            masters in parallel. The upper SEL_W address bits select the
//            slave. Read data returns to the granted master through a
//            per-master holding register.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   PCLK      in   1              clock, rising-edge active
//   PRESETN   in   1              asynchronous active-low reset
//   m_req     in   NUM_M          per-master request, held until m_ack
//   m_cmd     in   NUM_M          1 = write, 0 = read
//   m_addr    in   NUM_M*ADDR_W   master i at [i*ADDR_W +: ADDR_W]
//   m_wdata   in   NUM_M*DATA_W   master write data
//   m_ack     out  NUM_M          one-cycle completion pulse
//   m_rdata   out  NUM_M*DATA_W   registered read data, held between reads
//   s_ack     in   NUM_S          slave completion pulse
//   s_rdata   in   NUM_S*DATA_W   slave read data, valid with s_ack
//   s_req     out  NUM_S          request to each slave
//   s_cmd     out  NUM_S          command to each slave
//   s_addr    out  NUM_S*ADDR_W   full master address, unmodified
//   s_wdata   out  NUM_S*DATA_W   write data to each slave
// ============================================================================
module cross_bar_nxm #(
   parameter int NUM_M  = 2,
   parameter int NUM_S  = 2,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                       PCLK,
   input  logic                       PRESETN,
   input  logic [NUM_M-1:0]           m_req,
   input  logic [NUM_M-1:0]           m_cmd,
   input  logic [NUM_M*ADDR_W-1:0]    m_addr,
   input  logic [NUM_M*DATA_W-1:0]    m_wdata,
   output logic [NUM_M-1:0]           m_ack,
   output logic [NUM_M*DATA_W-1:0]    m_rdata,
   input  logic [NUM_S-1:0]           s_ack,
   input  logic [NUM_S*DATA_W-1:0]    s_rdata,
   output logic [NUM_S-1:0]           s_req,
   output logic [NUM_S-1:0]           s_cmd,
   output logic [NUM_S*ADDR_W-1:0]    s_addr,
   output logic [NUM_S*DATA_W-1:0]    s_wdata
);

   localparam int SEL_W = $clog2(NUM_S);
   localparam int GNT_W = (NUM_M > 1) ? $clog2(NUM_M) : 1;
   // One spare bit so pointer + offset never overflows before wrapping.
   localparam int IDX_W = GNT_W + 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_RESP  = 2'd2
   } state_t;

   // w_done[j][i]   : slave j completes a transaction for master i this cycle
   // w_rd_done[j][i]: same, and that transaction is a read
   logic [NUM_S-1:0][NUM_M-1:0] w_done;
   logic [NUM_S-1:0][NUM_M-1:0] w_rd_done;

   // =========================================================================
   // Per-slave arbiter and grant state machine
   // =========================================================================
   genvar gj;
   generate
      for (gj = 0; gj < NUM_S; gj++) begin : g_slave
         state_t             r_state;
         state_t             w_state_nxt;
         logic [GNT_W-1:0]   r_grant;
         logic [GNT_W-1:0]   w_grant_nxt;
         logic [GNT_W-1:0]   r_ptr;
         logic [GNT_W-1:0]   w_ptr_nxt;
         logic               r_cmd;
         logic               w_cmd_nxt;
         logic [NUM_M-1:0]   w_hit;
         logic               w_found;
         logic [GNT_W-1:0]   w_pick;
         logic [IDX_W-1:0]   w_idx;
         logic               w_in_grant;
         logic [NUM_M-1:0]   w_done_loc;
         logic [NUM_M-1:0]   w_rd_loc;

         // Masters currently requesting this slave.
         always_comb begin
            w_hit = '0;
            for (int i = 0; i < NUM_M; i++) begin
               w_hit[i] = m_req[i] &&
                  (m_addr[i*ADDR_W + ADDR_W - 1 -: SEL_W] == SEL_W'(gj));
            end
         end

         // Cyclic search starting at the round-robin pointer; the first hit
         // wins. The index wraps explicitly so NUM_M need not be a power of 2.
         always_comb begin
            w_found = 1'b0;
            w_pick  = '0;
            w_idx   = '0;
            for (int off = 0; off < NUM_M; off++) begin
               w_idx = IDX_W'(r_ptr) + IDX_W'(off);
               if (w_idx >= IDX_W'(NUM_M)) begin
                  w_idx = w_idx - IDX_W'(NUM_M);
               end
               if (!w_found && w_hit[w_idx[GNT_W-1:0]]) begin
                  w_found = 1'b1;
                  w_pick  = w_idx[GNT_W-1:0];
               end
            end
         end

         // Next-state logic.
         always_comb begin
            w_state_nxt = r_state;
            w_grant_nxt = r_grant;
            w_cmd_nxt   = r_cmd;
            w_ptr_nxt   = r_ptr;
            case (r_state)
               ST_IDLE: begin
                  if (w_found) begin
                     w_state_nxt = ST_GRANT;
                     w_grant_nxt = w_pick;
                     w_cmd_nxt   = m_cmd[w_pick];
                  end
               end
               ST_GRANT: begin
                  if (s_ack[gj]) begin
                     w_state_nxt = ST_RESP;
                     w_ptr_nxt   = (r_grant == GNT_W'(NUM_M - 1)) ?
                                   '0 : r_grant + GNT_W'(1);
                  end else if (!m_req[r_grant]) begin
                     // Abort: release the slave, keep the pointer so the
                     // aborting master does not lose its turn order.
                     w_state_nxt = ST_IDLE;
                  end
               end
               ST_RESP: begin
                  w_state_nxt = ST_IDLE;
               end
               default: begin
                  w_state_nxt = ST_IDLE;
               end
            endcase
         end

         always_ff @(posedge PCLK or negedge PRESETN) begin
            if (!PRESETN) begin
               r_state <= ST_IDLE;
               r_grant <= '0;
               r_cmd   <= 1'b0;
               r_ptr   <= '0;
            end else begin
               r_state <= w_state_nxt;
               r_grant <= w_grant_nxt;
               r_cmd   <= w_cmd_nxt;
               r_ptr   <= w_ptr_nxt;
            end
         end

         // Slave-side outputs are decoded from state, so an asynchronous
         // reset drops them without waiting for a clock edge. Address and
         // write data follow the granted master live.
         assign w_in_grant = (r_state == ST_GRANT);
         assign s_req[gj]  = w_in_grant && m_req[r_grant];
         assign s_cmd[gj]  = w_in_grant && r_cmd;
         assign s_addr[gj*ADDR_W +: ADDR_W] =
            w_in_grant ? m_addr[r_grant*ADDR_W +: ADDR_W] : '0;
         assign s_wdata[gj*DATA_W +: DATA_W] =
            w_in_grant ? m_wdata[r_grant*DATA_W +: DATA_W] : '0;

         // Completion is only recognised while a grant is held; a stray
         // s_ack in IDLE or RESP has no effect.
         always_comb begin
            w_done_loc = '0;
            w_rd_loc   = '0;
            for (int i = 0; i < NUM_M; i++) begin
               w_done_loc[i] = w_in_grant && s_ack[gj] &&
                               (r_grant == GNT_W'(i));
               w_rd_loc[i]   = w_done_loc[i] && !r_cmd;
            end
         end

         assign w_done[gj]    = w_done_loc;
         assign w_rd_done[gj] = w_rd_loc;
      end
   endgenerate

   // =========================================================================
   // Per-master acknowledge pulse and read-data holding register
   // =========================================================================
   genvar gi;
   generate
      for (gi = 0; gi < NUM_M; gi++) begin : g_master
         logic              r_ack;
         logic [DATA_W-1:0] r_rdata;
         logic              w_ack_any;
         logic              w_rd_any;
         logic [DATA_W-1:0] w_rd_data;

         // A well-behaved master has a single outstanding request, so at
         // most one slave completes for it in any cycle.
         always_comb begin
            w_ack_any = 1'b0;
            w_rd_any  = 1'b0;
            w_rd_data = '0;
            for (int j = 0; j < NUM_S; j++) begin
               if (w_done[j][gi]) begin
                  w_ack_any = 1'b1;
               end
               if (w_rd_done[j][gi]) begin
                  w_rd_any  = 1'b1;
                  w_rd_data = s_rdata[j*DATA_W +: DATA_W];
               end
            end
         end

         always_ff @(posedge PCLK or negedge PRESETN) begin
            if (!PRESETN) begin
               r_ack   <= 1'b0;
               r_rdata <= '0;
            end else begin
               r_ack <= w_ack_any;
               if (w_rd_any) begin
                  r_rdata <= w_rd_data;
               end
            end
         end

         assign m_ack[gi]                    = r_ack;
         assign m_rdata[gi*DATA_W +: DATA_W] = r_rdata;
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_cross_bar_nxm.sv
`default_nettype none
// ============================================================================
// Module   : tb_cross_bar_nxm
// Purpose  : Self-checking bench for cross_bar_nxm (4 masters x 4 slaves).
//            Expected completions are queued as stimulus is driven and are
//            popped and compared whenever the DUT pulses m_ack.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cross_bar_nxm;

   localparam int NM = 4;
   localparam int NS = 4;
   localparam int AW = 32;
   localparam int DW = 32;

   logic               PCLK;
   logic               PRESETN;
   logic [NM-1:0]      m_req;
   logic [NM-1:0]      m_cmd;
   logic [NM*AW-1:0]   m_addr;
   logic [NM*DW-1:0]   m_wdata;
   logic [NM-1:0]      m_ack;
   logic [NM*DW-1:0]   m_rdata;
   logic [NS-1:0]      s_ack;
   logic [NS*DW-1:0]   s_rdata;
   logic [NS-1:0]      s_req;
   logic [NS-1:0]      s_cmd;
   logic [NS*AW-1:0]   s_addr;
   logic [NS*DW-1:0]   s_wdata;

   cross_bar_nxm #(
      .NUM_M  (NM),
      .NUM_S  (NS),
      .ADDR_W (AW),
      .DATA_W (DW)
   ) u_dut (
      .PCLK    (PCLK),
      .PRESETN (PRESETN),
      .m_req   (m_req),
      .m_cmd   (m_cmd),
      .m_addr  (m_addr),
      .m_wdata (m_wdata),
      .m_ack   (m_ack),
      .m_rdata (m_rdata),
      .s_ack   (s_ack),
      .s_rdata (s_rdata),
      .s_req   (s_req),
      .s_cmd   (s_cmd),
      .s_addr  (s_addr),
      .s_wdata (s_wdata)
   );

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   typedef struct packed {
      logic [3:0]  m;
      logic [31:0] d;
   } exp_t;

   exp_t        sb_q[$];
   exp_t        mon_e;
   logic [31:0] mdl_rd [NM];
   int          n_chk  = 0;
   int          n_pass = 0;

   task automatic chk(input string tag, input logic [127:0] act,
                      input logic [127:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, act, exp);
   endtask

   task automatic tick();
      @(posedge PCLK);
      #1;
   endtask

   task automatic set_m(input int i, input logic req, input logic cmd,
                        input logic [31:0] a, input logic [31:0] d);
      m_req[i]            = req;
      m_cmd[i]            = cmd;
      m_addr[i*AW +: AW]  = a;
      m_wdata[i*DW +: DW] = d;
   endtask

   // Queue the completion expected for master i; a write leaves the held
   // read data unchanged.
   task automatic push(input int i, input logic is_rd, input logic [31:0] d);
      if (is_rd) mdl_rd[i] = d;
      sb_q.push_back({4'(i), mdl_rd[i]});
   endtask

   // Scoreboard consumer: every m_ack pulse must match a queued completion.
   always @(negedge PCLK) begin
      for (int i = 0; i < NM; i++) begin
         if (m_ack[i] === 1'b1) begin
            if (sb_q.size() == 0) begin
               chk("spurious_ack", 128'(m_ack), 128'(0));
            end else begin
               mon_e = sb_q.pop_front();
               chk("ack_master", 128'(i), 128'(mon_e.m));
               chk("ack_rdata", 128'(m_rdata[i*DW +: DW]), 128'(mon_e.d));
            end
         end
      end
   end

   initial begin
      int w;
      PRESETN = 1'b0;
      m_req = '0; m_cmd = '0; m_addr = '0; m_wdata = '0;
      s_ack = '0; s_rdata = '0;
      for (int i = 0; i < NM; i++) mdl_rd[i] = '0;

      // ---- reset with random inputs: all outputs held at zero -------------
      for (int r = 0; r < 3; r++) begin
         m_req   = 4'($urandom);
         m_cmd   = 4'($urandom);
         m_addr  = {$urandom, $urandom, $urandom, $urandom};
         m_wdata = {$urandom, $urandom, $urandom, $urandom};
         s_ack   = 4'($urandom);
         s_rdata = {$urandom, $urandom, $urandom, $urandom};
         tick();
         chk("rst_m_ack",   128'(m_ack),   128'(0));
         chk("rst_m_rdata", m_rdata,       128'(0));
         chk("rst_s_req",   128'(s_req),   128'(0));
         chk("rst_s_cmd",   128'(s_cmd),   128'(0));
         chk("rst_s_addr",  s_addr,        128'(0));
         chk("rst_s_wdata", s_wdata,       128'(0));
      end
      m_req = '0; m_cmd = '0; m_addr = '0; m_wdata = '0;
      s_ack = '0; s_rdata = '0;
      tick();
      PRESETN = 1'b1;
      tick();
      tick();

      // ---- single read: m1 -> slave 2 -------------------------------------
      set_m(1, 1'b1, 1'b0, 32'h8000_0010, 32'h0);
      tick();
      chk("rd_s_req",  128'(s_req), 128'(4'b0100));
      chk("rd_s_addr", 128'(s_addr[2*AW +: AW]), 128'(32'h8000_0010));
      chk("rd_s_cmd",  128'(s_cmd), 128'(0));
      s_ack[2] = 1'b1;
      s_rdata[2*DW +: DW] = 32'hDEAD_BEEF;
      push(1, 1'b1, 32'hDEAD_BEEF);
      tick();
      chk("rd_m_ack",      128'(m_ack), 128'(4'b0010));
      chk("rd_resp_s_req", 128'(s_req), 128'(0));
      s_ack = '0;
      s_rdata = '0;
      m_req[1] = 1'b0;
      tick();
      chk("rd_ack_once", 128'(m_ack), 128'(0));
      tick();
      tick();
      chk("rd_hold", 128'(m_rdata[1*DW +: DW]), 128'(32'hDEAD_BEEF));

      // ---- round robin: all masters -> slave 0, immediate acks ------------
      for (int i = 0; i < NM; i++) set_m(i, 1'b1, 1'b0, 32'((i + 1) << 8), 32'h0);
      for (int k = 0; k < 5; k++) begin
         w = 0;
         do begin
            tick();
            s_ack = '0;
            w++;
         end while (s_req[0] !== 1'b1 && w < 10);
         chk("rr_gap", 128'(w), 128'((k == 0) ? 1 : 3));
         chk("rr_grant", 128'(s_addr[0 +: AW]), 128'(((k % NM) + 1) << 8));
         s_ack[0] = 1'b1;
         s_rdata[0 +: DW] = 32'hA000_0000 + 32'(k);
         push(k % NM, 1'b1, 32'hA000_0000 + 32'(k));
      end
      tick();
      s_ack = '0;
      m_req = '0;
      tick();
      tick();

      // ---- parallel: m0 writes slave 0, m3 reads slave 3 ------------------
      set_m(0, 1'b1, 1'b1, 32'h0000_0040, 32'h5555_AAAA);
      set_m(3, 1'b1, 1'b0, 32'hC000_0020, 32'h0);
      tick();
      chk("par_s_req", 128'(s_req), 128'(4'b1001));
      chk("par_s_cmd", 128'(s_cmd), 128'(4'b0001));
      chk("par_s_wdata0", 128'(s_wdata[0 +: DW]), 128'(32'h5555_AAAA));
      s_ack = 4'b1001;
      s_rdata[0 +: DW]    = 32'h0BAD_0BAD;
      s_rdata[3*DW +: DW] = 32'h3333_CCCC;
      push(0, 1'b0, 32'h0);
      push(3, 1'b1, 32'h3333_CCCC);
      tick();
      chk("par_m_ack", 128'(m_ack), 128'(4'b1001));
      s_ack = '0;
      s_rdata = '0;
      m_req = '0;
      tick();
      tick();

      // ---- abort, stray ack, pointer unchanged ----------------------------
      set_m(2, 1'b1, 1'b0, 32'h4000_0000, 32'h0);
      tick();
      chk("ab_s_req", 128'(s_req), 128'(4'b0010));
      m_req[2] = 1'b0;
      #1;
      chk("ab_s_req_drop", 128'(s_req), 128'(0));
      tick();
      tick();
      s_ack[1] = 1'b1;
      s_rdata[1*DW +: DW] = 32'hFFFF_FFFF;
      tick();
      s_ack = '0;
      s_rdata = '0;
      tick();
      chk("ab_no_ack", 128'(m_ack), 128'(0));
      set_m(1, 1'b1, 1'b0, 32'h4000_0100, 32'h0);
      set_m(3, 1'b1, 1'b0, 32'h4000_0300, 32'h0);
      tick();
      chk("ab_ptr_grant", 128'(s_addr[1*AW +: AW]), 128'(32'h4000_0100));
      s_ack[1] = 1'b1;
      s_rdata[1*DW +: DW] = 32'h1111_2222;
      push(1, 1'b1, 32'h1111_2222);
      tick();
      s_ack = '0;
      s_rdata = '0;
      m_req = '0;
      tick();
      tick();

      // ---- write: m0 -> slave 0, ack in second GRANT cycle ----------------
      set_m(0, 1'b1, 1'b1, 32'h0000_0008, 32'h1234_5678);
      tick();
      chk("wr_cmd1",   128'(s_cmd[0]), 128'(1));
      chk("wr_wdata1", 128'(s_wdata[0 +: DW]), 128'(32'h1234_5678));
      tick();
      chk("wr_cmd2",   128'(s_cmd[0]), 128'(1));
      chk("wr_wdata2", 128'(s_wdata[0 +: DW]), 128'(32'h1234_5678));
      s_ack[0] = 1'b1;
      s_rdata[0 +: DW] = 32'hBEEF_0000;
      push(0, 1'b0, 32'h0);
      tick();
      s_ack = '0;
      s_rdata = '0;
      m_req = '0;
      tick();
      chk("wr_rdata_keep", 128'(m_rdata[0 +: DW]), 128'(mdl_rd[0]));

      // ---- reset asserted mid-GRANT ---------------------------------------
      set_m(1, 1'b1, 1'b0, 32'h8000_0000, 32'h0);
      tick();
      chk("rm_s_req", 128'(s_req), 128'(4'b0100));
      s_ack[2] = 1'b1;
      #2;
      PRESETN = 1'b0;
      #1;
      chk("rm_s_req_drop", 128'(s_req), 128'(0));
      for (int i = 0; i < NM; i++) mdl_rd[i] = '0;
      tick();
      chk("rm_m_ack",  128'(m_ack), 128'(0));
      chk("rm_rdata",  m_rdata,     128'(0));
      s_ack = '0;
      m_req = '0;
      tick();
      PRESETN = 1'b1;
      tick();
      tick();
      chk("rm_m_ack_after", 128'(m_ack), 128'(0));

      chk("sb_empty", 128'(sb_q.size()), 128'(0));
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
